// File: rtl/resq_dispatch_core.sv
// Multi-class relief dispatcher: class 0 is a strict evacuation FIFO, classes 1.. are aged priority queues.
// Optional feature macro: RESQ_AGING_EN (age counters, boost ranking and Out_Boost).
module resq_dispatch_core #(
  parameter int NUM_CLASSES = 3,
  parameter int DEPTH       = 8,
  parameter int ZONE_W      = 8,
  parameter int PRIO_W      = 2,
  parameter int AGE_LIMIT   = 20
) (
  input  logic                           Clock,
  input  logic                           Reset_Queue,
  input  logic                           Insert,
  input  logic [$clog2(NUM_CLASSES)-1:0] Class,
  input  logic [ZONE_W-1:0]              Zone,
  input  logic [PRIO_W-1:0]              Priority,
  input  logic                           Serve,
  output logic                           Out_Valid,
  output logic [$clog2(NUM_CLASSES)-1:0] Out_Class,
  output logic [ZONE_W-1:0]              Out_Zone,
  output logic [PRIO_W-1:0]              Out_Priority,
  output logic                           Out_Boost,
  output logic [NUM_CLASSES-1:0]         Full,
  output logic [NUM_CLASSES-1:0]         Empty,
  output logic                           Insert_Drop
);

  localparam int CW = $clog2(NUM_CLASSES);
  localparam int SW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [ZONE_W-1:0]      zone_r     [NUM_CLASSES][DEPTH];
  logic [PRIO_W-1:0]      prio_r     [NUM_CLASSES][DEPTH];
  logic [NW-1:0]          cnt_r      [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] full_r;
  logic [NUM_CLASSES-1:0] empty_r;
  logic                   drop_r;

  logic [ZONE_W-1:0]      zone_nxt_s [NUM_CLASSES][DEPTH];
  logic [PRIO_W-1:0]      prio_nxt_s [NUM_CLASSES][DEPTH];
  logic [NW-1:0]          cnt_nxt_s  [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] full_nxt_s;
  logic [NUM_CLASSES-1:0] empty_nxt_s;
  logic                   drop_nxt_s;

`ifdef RESQ_AGING_EN
  localparam int AW = 8;
  logic [AW-1:0]          age_r      [NUM_CLASSES][DEPTH];
  logic [AW-1:0]          age_nxt_s  [NUM_CLASSES][DEPTH];
`endif

  logic                   head_valid_s;
  logic [CW-1:0]          head_cls_s;
  logic [SW-1:0]          head_slot_s;
  logic [ZONE_W-1:0]      head_zone_s;
  logic [PRIO_W-1:0]      head_prio_s;
  logic                   head_boost_s;
  logic                   cand_boost_s;

  logic                   pop_s;
  logic                   cancel_s;
  logic                   class_ok_s;
  logic                   keep_s;
  int                     wp_s;

  assign class_ok_s = (int'(Class) < NUM_CLASSES);
  assign cancel_s   = Insert && (Class == {CW{1'b0}});
  assign pop_s      = Serve && head_valid_s;

  // Head selection: evac FIFO head wins outright, otherwise best-ranked entry among classes 1..
  always_comb begin
    head_valid_s = 1'b0;
    head_cls_s   = {CW{1'b0}};
    head_slot_s  = {SW{1'b0}};
    head_zone_s  = {ZONE_W{1'b0}};
    head_prio_s  = {PRIO_W{1'b0}};
    head_boost_s = 1'b0;
    cand_boost_s = 1'b0;
    if (cnt_r[0] != {NW{1'b0}}) begin
      head_valid_s = 1'b1;
      head_zone_s  = zone_r[0][0];
      head_prio_s  = prio_r[0][0];
    end else begin
      // Ascending class/slot scan with strict improvement keeps the lowest class, oldest slot on ties.
      for (int c = 1; c < NUM_CLASSES; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
`ifdef RESQ_AGING_EN
          cand_boost_s = (age_r[c][s] == AW'(AGE_LIMIT));
`else
          cand_boost_s = 1'b0;
`endif
          if ((s < int'(cnt_r[c])) &&
              (!head_valid_s || (cand_boost_s && !head_boost_s) ||
               ((cand_boost_s == head_boost_s) && (prio_r[c][s] > head_prio_s)))) begin
            head_valid_s = 1'b1;
            head_cls_s   = CW'(c);
            head_slot_s  = SW'(s);
            head_zone_s  = zone_r[c][s];
            head_prio_s  = prio_r[c][s];
            head_boost_s = cand_boost_s;
          end else begin
            head_valid_s = head_valid_s;
          end
        end
      end
    end
  end

  // Next state: drop served/cancelled entries, compact survivors, age them, then append the insert.
  always_comb begin
    zone_nxt_s  = '{default: '0};
    prio_nxt_s  = '{default: '0};
    cnt_nxt_s   = '{default: '0};
`ifdef RESQ_AGING_EN
    age_nxt_s   = '{default: '0};
`endif
    full_nxt_s  = {NUM_CLASSES{1'b0}};
    empty_nxt_s = {NUM_CLASSES{1'b0}};
    drop_nxt_s  = Insert && !class_ok_s;
    keep_s      = 1'b0;
    wp_s        = 0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      wp_s = 0;
      for (int s = 0; s < DEPTH; s++) begin
        // A served entry that also matches the cancel zone is simply not kept: one removal only.
        keep_s = (s < int'(cnt_r[c])) &&
                 !(pop_s && (int'(head_cls_s) == c) && (int'(head_slot_s) == s)) &&
                 !(cancel_s && (c != 0) && (zone_r[c][s] == Zone));
        if (keep_s) begin
          zone_nxt_s[c][SW'(wp_s)] = zone_r[c][s];
          prio_nxt_s[c][SW'(wp_s)] = prio_r[c][s];
`ifdef RESQ_AGING_EN
          if ((c != 0) && (age_r[c][s] < AW'(AGE_LIMIT))) begin
            age_nxt_s[c][SW'(wp_s)] = age_r[c][s] + 8'd1;
          end else begin
            age_nxt_s[c][SW'(wp_s)] = age_r[c][s];
          end
`endif
          wp_s = wp_s + 1;
        end else begin
          wp_s = wp_s;
        end
      end
      if (Insert && class_ok_s && (int'(Class) == c)) begin
        if (wp_s < DEPTH) begin
          zone_nxt_s[c][SW'(wp_s)] = Zone;
          prio_nxt_s[c][SW'(wp_s)] = Priority;
          wp_s = wp_s + 1;
        end else begin
          drop_nxt_s = 1'b1;
        end
      end else begin
        wp_s = wp_s;
      end
      cnt_nxt_s[c]   = NW'(wp_s);
      full_nxt_s[c]  = (wp_s == DEPTH);
      empty_nxt_s[c] = (wp_s == 0);
    end
  end

  // State register with synchronous queue reset.
  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      zone_r  <= '{default: '0};
      prio_r  <= '{default: '0};
      cnt_r   <= '{default: '0};
`ifdef RESQ_AGING_EN
      age_r   <= '{default: '0};
`endif
      full_r  <= {NUM_CLASSES{1'b0}};
      empty_r <= {NUM_CLASSES{1'b1}};
      drop_r  <= 1'b0;
    end else begin
      zone_r  <= zone_nxt_s;
      prio_r  <= prio_nxt_s;
      cnt_r   <= cnt_nxt_s;
`ifdef RESQ_AGING_EN
      age_r   <= age_nxt_s;
`endif
      full_r  <= full_nxt_s;
      empty_r <= empty_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  assign Out_Valid    = head_valid_s;
  assign Out_Class    = head_cls_s;
  assign Out_Zone     = head_zone_s;
  assign Out_Priority = head_prio_s;
  assign Out_Boost    = head_boost_s;
  assign Full         = full_r;
  assign Empty        = empty_r;
  assign Insert_Drop  = drop_r;

endmodule

// File: doc/resq_dispatch_core.md
# resq_dispatch_core

Parametrised multi-class relief dispatcher: NUM_CLASSES request queues of DEPTH entries each behind a single Insert/Serve interface. Class 0 is the evacuation class, a strict FIFO that preempts everything. Classes 1..NUM_CLASSES-1 are priority queues with age-based boost. An evacuation insert cancels pending non-evac requests for the same zone. The block sits between the operator input decoder and the dispatch display/output stage, and generalises the fixed food/shelter/evac top level to any class count and depth.

## Interface
- NUM_CLASSES, 3: number of resource classes (2..8); class 0 = evacuation.
- DEPTH, 8: entries per class queue (2..16).
- ZONE_W, 8: zone ID width.
- PRIO_W, 2: priority width; larger value = more urgent.
- AGE_LIMIT, 20: cycles an entry waits before it is boosted (1..255).
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_Queue  in  1  synchronous, active-high reset; empties all queues.
- Insert  in  1  one-cycle insert strobe.
- Class  in  $clog2(NUM_CLASSES)  target class of the insert.
- Zone  in  ZONE_W  zone of the insert (also the cancel key).
- Priority  in  PRIO_W  priority of the insert (stored, ignored for selection in class 0).
- Serve  in  1  one-cycle pop strobe for the current head.
- Out_Valid  out  1  a head entry exists.
- Out_Class  out  $clog2(NUM_CLASSES)  class of the head.
- Out_Zone  out  ZONE_W  zone of the head.
- Out_Priority  out  PRIO_W  priority of the head.
- Out_Boost  out  1  head was selected due to age boost.
- Full  out  NUM_CLASSES  per-class full flag.
- Empty  out  NUM_CLASSES  per-class empty flag.
- Insert_Drop  out  1  registered pulse: previous-cycle insert rejected.

## Operation
- Storage: per class, a compacting array. Slot 0 holds the oldest entry. Each entry holds zone, priority and age.
- Insert: the entry is appended at the class's tail with age 0.
  - Dropped (Insert_Drop = 1 next cycle) when Class >= NUM_CLASSES.
  - Also dropped when the class is full and not popped in the same cycle.
- Age: increments by 1 per cycle for every valid entry in classes >= 1. Saturates at AGE_LIMIT. An entry is boosted when age == AGE_LIMIT.
- Evac cancel: an accepted or dropped Insert with Class == 0 removes every entry in classes >= 1 whose zone equals Zone. The class-0 entry itself is still appended if there is space.
- Head selection (combinational from registered state):
  - If Empty[0] = 0: the head is class-0 slot 0 and Out_Boost = 0.
  - Otherwise, candidates are all valid entries in classes >= 1, ranked by:
    1. boosted entries first;
    2. then higher priority;
    3. then lower class index;
    4. then lower slot (older).
  - Out_Boost = 1 only if the winning entry is boosted.
- Serve: when Out_Valid = 1, removes the head entry and compacts its class. Serve with Out_Valid = 0 is ignored.
- Outputs when Out_Valid = 0: Out_Class, Out_Zone, Out_Priority and Out_Boost are all 0.

## Timing
- Reset values: Out_Valid 0, Out_Class/Zone/Priority/Boost 0, Full all 0, Empty all 1, Insert_Drop 0. All storage and ages are cleared.
- Reset_Queue has priority. Insert and Serve in a reset cycle are ignored. A reset issued mid-operation clears all queued entries at that edge.
- Insert latency: an entry appears at the head candidate set one cycle after its Insert edge.
- Serve latency: the next head is presented one cycle after the Serve edge.
- Same-cycle Insert + Serve:
  - Serve acts on the pre-edge state.
  - An insert into a full class that is popped in the same cycle is accepted.
  - Age increments apply to surviving entries only.
- Same-cycle evac cancel + Serve of a matching entry: the entry is removed once, with no double compaction.
- Full[c] = count == DEPTH and Empty[c] = count == 0, both registered and consistent with the stored count.

## Configuration
- RESQ_AGING_EN defined: age counters, boost ranking and Out_Boost are implemented as above.
- Not defined: no age storage is built, Out_Boost is tied to 0, and classes >= 1 rank by priority, then class index, then slot.

## Test plan
- Reset, then Insert class 1 zone 0x05 prio 2 -> next cycle Out_Valid = 1, Out_Class = 1, Out_Zone = 0x05, Empty = 3'b101.
- Class 1 zone 0x11 prio 1 and class 2 zone 0x22 prio 3 queued, then Insert class 0 zone 0x33 -> head class 0 zone 0x33. Serve -> head zone 0x22. Serve -> head zone 0x11.
- Queue class 1 zone 0x44 and class 2 zone 0x44, then Insert class 0 zone 0x44 -> both cancelled, Empty[1] = Empty[2] = 1. Serve -> Out_Valid = 0.
- Fill class 2 with DEPTH inserts, insert one more -> Insert_Drop = 1, Full[2] = 1. Repeat the insert while the class-2 head is served -> accepted, Insert_Drop = 0.
- RESQ_AGING_EN: class 1 prio 0 inserted, then class 2 prio 3 inserted each time it is served, for 20 cycles -> class 1 entry wins with Out_Boost = 1.
- Insert with Class = 3 (NUM_CLASSES = 3) -> Insert_Drop = 1, no state change. Assert Reset_Queue with 5 entries queued -> next cycle Empty = all 1 and Out_Valid = 0.
